// File: rtl/scene_raster_engine.sv
// ---------------------------------------------------------------------------
// scene_raster_engine
//
// Purpose: command-driven pixel generator for a lane-based side-scroller
// scene. One command at a time is latched and scanned in raster order
// (x fastest). Each scanned position produces one candidate pixel on the
// registered x/y/color outputs with a plot strobe. The downstream side
// consumes the pixel with plot_ready.
//
// Commands (cmd_op):
//   00 CLEAR  : full screen, floor bands in FLOOR_COLOR, rest BG_COLOR
//   01 FLOORS : full width, floor-band rows only, FLOOR_COLOR
//   10 SPRITE : SPR_W x SPR_H bitmap at (cmd_x, cmd_y) in cmd_color
//   11 COLUMN : COL_W-wide wall from cmd_x, all rows, with per-lane gaps
//
// Ports:
//   clk, reset_n             clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready    command handshake (ready only while idle)
//   cmd_op, cmd_x, cmd_y     command code and region origin
//   cmd_color, cmd_shape     sprite/wall colour, 2-bit shape code per lane
//   sprite_bits              sprite bitmap, bit r*SPR_W+c = row r, col c
//   plot / plot_ready        pixel strobe and downstream acceptance
//   x, y, color              registered pixel coordinate and colour
//   busy, done               command executing, one-cycle completion pulse
// ---------------------------------------------------------------------------
module scene_raster_engine #(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int COLOR_W    = 3,
  parameter int NUM_LANES  = 3,
  parameter int LANE_PITCH = 40,
  parameter int FLOOR_H    = 5,
  parameter int TOP_GAP_H  = 15,
  parameter int BOT_GAP_H  = 5,
  parameter int COL_W      = 2,
  parameter int SPR_W      = 7,
  parameter int SPR_H      = 7,
  parameter logic [COLOR_W-1:0] FLOOR_COLOR = 3'b010,
  parameter logic [COLOR_W-1:0] BG_COLOR    = 3'b000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [X_W-1:0]           cmd_x,
  input  logic [Y_W-1:0]           cmd_y,
  input  logic [COLOR_W-1:0]       cmd_color,
  input  logic [2*NUM_LANES-1:0]   cmd_shape,
  input  logic [SPR_W*SPR_H-1:0]   sprite_bits,
  output logic                     plot,
  input  logic                     plot_ready,
  output logic [X_W-1:0]           x,
  output logic [Y_W-1:0]           y,
  output logic [COLOR_W-1:0]       color,
  output logic                     busy,
  output logic                     done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_CLEAR  = 2'b00;
  localparam logic [1:0] OP_FLOORS = 2'b01;
  localparam logic [1:0] OP_SPRITE = 2'b10;
  localparam logic [1:0] OP_COLUMN = 2'b11;

  // One guard bit above the screen coordinate width so that region
  // offsets past the right/bottom edge are detected instead of wrapping.
  localparam int XG_W        = X_W + 1;
  localparam int YG_W        = Y_W + 1;
  localparam int LANE_W      = $clog2(NUM_LANES + 1);
  localparam int ROW_W       = $clog2(LANE_PITCH);
  localparam int FLOOR_START = LANE_PITCH - FLOOR_H;
  localparam int BOT_START   = FLOOR_START - BOT_GAP_H;
  localparam int SHAPE_W     = 2 * NUM_LANES;
  localparam int BITS_W      = SPR_W * SPR_H;

  logic [1:0]         state;

  logic [1:0]         op_q,    nxt_op;
  logic [X_W-1:0]     org_x_q, nxt_org_x;
  logic [Y_W-1:0]     org_y_q, nxt_org_y;
  logic [COLOR_W-1:0] col_q,   nxt_color;
  logic [SHAPE_W-1:0] shape_q, nxt_shape;
  logic [BITS_W-1:0]  bits_q,  nxt_bits;

  // sx/sy are offsets inside the region; lane/row track which lane and
  // which row within that lane the current scan row falls in, so lane
  // geometry never needs a divide.
  logic [XG_W-1:0]    sx_q,    nxt_sx;
  logic [YG_W-1:0]    sy_q,    nxt_sy;
  logic [LANE_W-1:0]  lane_q,  nxt_lane;
  logic [ROW_W-1:0]   row_q,   nxt_row;

  logic               accept;
  logic               advance;
  logic [XG_W-1:0]    last_x;
  logic               last_col;
  logic               last_row;
  logic               scan_last;

  logic [XG_W-1:0]    pix_ax;
  logic [YG_W-1:0]    pix_ay;
  logic               clipped;
  logic               in_floor;
  logic               in_top;
  logic               in_bot;
  logic [1:0]         lane_code;
  logic [BITS_W-1:0]  spr_shift;
  logic               spr_bit;
  logic               pix_plot;
  logic [COLOR_W-1:0] pix_color;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);

  // Scan sequencing: decide the next scan position. On accept the command
  // fields come straight from the inputs so the first pixel can be
  // registered on the accept edge. The scan only moves when the current
  // pixel is either not a plot or has been taken downstream.
  always_comb begin
    accept  = (state == S_IDLE) && cmd_valid;
    advance = (state == S_RUN) && (!plot || plot_ready);

    case (op_q)
      OP_SPRITE: last_x = XG_W'(SPR_W - 1);
      OP_COLUMN: last_x = XG_W'(COL_W - 1);
      default:   last_x = XG_W'(SCREEN_W - 1);
    endcase
    last_col = (sx_q == last_x);

    case (op_q)
      OP_SPRITE: last_row = (sy_q == YG_W'(SPR_H - 1));
      OP_FLOORS: last_row = (lane_q == LANE_W'(NUM_LANES - 1)) &&
                            (row_q == ROW_W'(LANE_PITCH - 1));
      default:   last_row = (sy_q == YG_W'(SCREEN_H - 1));
    endcase
    scan_last = last_col && last_row;

    nxt_op    = op_q;
    nxt_org_x = org_x_q;
    nxt_org_y = org_y_q;
    nxt_color = col_q;
    nxt_shape = shape_q;
    nxt_bits  = bits_q;
    nxt_sx    = sx_q;
    nxt_sy    = sy_q;
    nxt_lane  = lane_q;
    nxt_row   = row_q;

    if (accept) begin
      nxt_op    = cmd_op;
      nxt_org_x = cmd_x;
      nxt_org_y = cmd_y;
      nxt_color = cmd_color;
      nxt_shape = cmd_shape;
      nxt_bits  = sprite_bits;
      nxt_sx    = '0;
      nxt_lane  = '0;
      if (cmd_op == OP_FLOORS) begin
        nxt_sy  = YG_W'(FLOOR_START);
        nxt_row = ROW_W'(FLOOR_START);
      end else begin
        nxt_sy  = '0;
        nxt_row = '0;
      end
    end else if (advance && !scan_last) begin
      if (!last_col) begin
        nxt_sx = sx_q + 1'b1;
      end else begin
        nxt_sx = '0;
        if (row_q == ROW_W'(LANE_PITCH - 1)) begin
          nxt_lane = lane_q + 1'b1;
          if (op_q == OP_FLOORS) begin
            // Skip straight from this band's last row to the next band.
            nxt_sy  = sy_q + YG_W'(FLOOR_START + 1);
            nxt_row = ROW_W'(FLOOR_START);
          end else begin
            nxt_sy  = sy_q + 1'b1;
            nxt_row = '0;
          end
        end else begin
          nxt_sy  = sy_q + 1'b1;
          nxt_row = row_q + 1'b1;
        end
      end
    end
  end

  // Pixel generation for the next scan position: absolute coordinate with
  // guard bit, clipping, and the colour rules of each command.
  always_comb begin
    pix_ax = nxt_sx;
    pix_ay = nxt_sy;
    if (nxt_op == OP_SPRITE || nxt_op == OP_COLUMN)
      pix_ax = nxt_sx + XG_W'(nxt_org_x);
    if (nxt_op == OP_SPRITE)
      pix_ay = nxt_sy + YG_W'(nxt_org_y);

    clipped  = (pix_ax >= XG_W'(SCREEN_W)) || (pix_ay >= YG_W'(SCREEN_H));
    in_floor = (nxt_row >= ROW_W'(FLOOR_START));
    in_top   = (nxt_row < ROW_W'(TOP_GAP_H));
    in_bot   = (nxt_row >= ROW_W'(BOT_START)) && !in_floor;

    lane_code = 2'(nxt_shape >> {nxt_lane, 1'b0});
    spr_shift = nxt_bits >> (int'(nxt_sy) * SPR_W + int'(nxt_sx));
    spr_bit   = spr_shift[0];

    pix_plot  = !clipped;
    pix_color = BG_COLOR;
    case (nxt_op)
      OP_CLEAR:  pix_color = in_floor ? FLOOR_COLOR : BG_COLOR;
      OP_FLOORS: pix_color = FLOOR_COLOR;
      OP_SPRITE: begin
        pix_plot  = spr_bit && !clipped;
        pix_color = nxt_color;
      end
      default: begin
        // Shapes 10/11 close the top gap; only shape 10 opens the bottom gap.
        if (in_floor)
          pix_color = FLOOR_COLOR;
        else if (in_top)
          pix_color = lane_code[1] ? nxt_color : BG_COLOR;
        else if (in_bot)
          pix_color = (lane_code == 2'b10) ? BG_COLOR : nxt_color;
        else
          pix_color = nxt_color;
      end
    endcase
  end

  // State, latched command and scan counters, plus the registered pixel.
  // A clipped position keeps the previous x/y/color so an off-screen
  // offset never shows up as a wrapped coordinate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      op_q    <= '0;
      org_x_q <= '0;
      org_y_q <= '0;
      col_q   <= '0;
      shape_q <= '0;
      bits_q  <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      lane_q  <= '0;
      row_q   <= '0;
      plot    <= 1'b0;
      x       <= '0;
      y       <= '0;
      color   <= '0;
    end else begin
      op_q    <= nxt_op;
      org_x_q <= nxt_org_x;
      org_y_q <= nxt_org_y;
      col_q   <= nxt_color;
      shape_q <= nxt_shape;
      bits_q  <= nxt_bits;
      sx_q    <= nxt_sx;
      sy_q    <= nxt_sy;
      lane_q  <= nxt_lane;
      row_q   <= nxt_row;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_RUN;
            plot  <= pix_plot;
            if (!clipped) begin
              x     <= pix_ax[X_W-1:0];
              y     <= pix_ay[Y_W-1:0];
              color <= pix_color;
            end
          end
        end
        S_RUN: begin
          if (advance) begin
            if (scan_last) begin
              state <= S_DONE;
              plot  <= 1'b0;
            end else begin
              plot <= pix_plot;
              if (!clipped) begin
                x     <= pix_ax[X_W-1:0];
                y     <= pix_ay[Y_W-1:0];
                color <= pix_color;
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scene_raster_engine.sv
// ---------------------------------------------------------------------------
// tb_scene_raster_engine
//
// Purpose: self-checking bench for scene_raster_engine. A table of command
// records is applied in a loop; for each one an expected pixel stream is
// built from the screen geometry and queued, then popped as the engine
// delivers pixels. Reset behaviour and mid-command abort are hand-written.
// ---------------------------------------------------------------------------
module tb_scene_raster_engine;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic [2:0]  cmd_color;
  logic [5:0]  cmd_shape;
  logic [48:0] sprite_bits;
  logic        plot;
  logic        plot_ready;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  color;
  logic        busy;
  logic        done;

  typedef struct {
    logic [1:0]  op;
    int          px;
    int          py;
    logic [2:0]  col;
    logic [5:0]  shape;
    logic [48:0] bits;
    int          stall_at;
    int          exp_plots;
    int          exp_cycles;
  } vec_t;

  typedef struct {
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
  } pix_t;

  vec_t vecs[8];
  pix_t exp_q[$];
  int   tests;
  int   fails;

  scene_raster_engine dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_color   (cmd_color),
    .cmd_shape   (cmd_shape),
    .sprite_bits (sprite_bits),
    .plot        (plot),
    .plot_ready  (plot_ready),
    .x           (x),
    .y           (y),
    .color       (color),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Expected colour from the screen geometry: lane = row / pitch.
  function automatic logic [2:0] model_color(input logic [1:0] op, input int ay,
                                             input logic [2:0] col, input logic [5:0] shape);
    int         lane;
    int         row;
    logic [5:0] s;
    logic [1:0] code;
    lane = ay / 40;
    row  = ay % 40;
    s    = shape;
    code = 2'(s >> (2 * lane));
    if (op == 2'b10) return col;
    if (row >= 35) return 3'b010;
    if (op == 2'b00) return 3'b000;
    if (row < 15) return (code == 2'b00 || code == 2'b01) ? 3'b000 : col;
    if (row >= 30) return (code == 2'b10) ? 3'b000 : col;
    return col;
  endfunction

  task automatic push_pix(input int ax, input int ay, input logic [2:0] c);
    pix_t p;
    p.px = 8'(ax);
    p.py = 7'(ay);
    p.pc = c;
    exp_q.push_back(p);
  endtask

  task automatic build_expected(input vec_t v);
    exp_q.delete();
    case (v.op)
      2'b00: for (int ay = 0; ay < 120; ay++)
               for (int ax = 0; ax < 160; ax++)
                 push_pix(ax, ay, model_color(v.op, ay, v.col, v.shape));
      2'b01: for (int ay = 0; ay < 120; ay++)
               if (ay % 40 >= 35)
                 for (int ax = 0; ax < 160; ax++)
                   push_pix(ax, ay, 3'b010);
      2'b10: for (int r = 0; r < 7; r++)
               for (int c = 0; c < 7; c++)
                 if (v.bits[r*7+c] && (v.px + c < 160) && (v.py + r < 120))
                   push_pix(v.px + c, v.py + r, v.col);
      default: for (int ay = 0; ay < 120; ay++)
                 for (int c = 0; c < 2; c++)
                   if (v.px + c < 160)
                     push_pix(v.px + c, ay, model_color(v.op, ay, v.col, v.shape));
    endcase
  endtask

  // Drive one command, then follow it cycle by cycle (sampled on the
  // falling edge) until done, comparing every offered pixel with the queue.
  // Cycle 0 is the accept cycle; the first pixel shows in cycle 1.
  task automatic apply_stimulus(input int vi, input bit no_wait);
    vec_t v;
    int   cyc;
    int   plots;
    int   done_cyc;
    pix_t e;
    v = vecs[vi];
    build_expected(v);
    if (!no_wait) @(negedge clk);
    cmd_op      = v.op;
    cmd_x       = 8'(v.px);
    cmd_y       = 7'(v.py);
    cmd_color   = v.col;
    cmd_shape   = v.shape;
    sprite_bits = v.bits;
    cmd_valid   = 1'b1;
    plot_ready  = 1'b1;
    check_output("ready_before_accept", cmd_ready, 1);
    @(negedge clk);
    cmd_valid   = 1'b0;
    cmd_op      = 2'($urandom);
    cmd_x       = 8'($urandom);
    cmd_y       = 7'($urandom);
    cmd_color   = 3'($urandom);
    cmd_shape   = 6'($urandom);
    sprite_bits = 49'({$urandom, $urandom});
    cyc      = 1;
    plots    = 0;
    done_cyc = -1;
    while (cyc <= v.exp_cycles + 20) begin
      plot_ready = !(v.stall_at > 0 && cyc >= v.stall_at && cyc < v.stall_at + 3);
      if (cyc == 1) begin
        check_output("busy_first_cycle", busy, 1);
        check_output("ready_while_busy", cmd_ready, 0);
      end
      if (done) begin
        done_cyc = cyc;
        check_output("plot_in_done", plot, 0);
        break;
      end
      if (plot) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_plot", 1, 0);
        end else begin
          e = exp_q[0];
          check_output($sformatf("pixel_v%0d_n%0d", vi, plots),
                       int'({x, y, color}), int'({e.px, e.py, e.pc}));
          if (plot_ready) begin
            void'(exp_q.pop_front());
            plots++;
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    plot_ready = 1'b1;
    check_output($sformatf("plots_v%0d", vi), plots, v.exp_plots);
    check_output($sformatf("done_cycle_v%0d", vi), done_cyc, v.exp_cycles);
    check_output($sformatf("leftover_v%0d", vi), exp_q.size(), 0);
    @(negedge clk);
    check_output("done_one_cycle", done, 0);
    check_output("ready_after_done", cmd_ready, 1);
    check_output("busy_after_done", busy, 0);
  endtask

  initial begin
    int plots;
    int cyc;
    tests       = 0;
    fails       = 0;
    reset_n     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = 2'b00;
    cmd_x       = '0;
    cmd_y       = '0;
    cmd_color   = '0;
    cmd_shape   = '0;
    sprite_bits = '0;
    plot_ready  = 1'b1;

    vecs[0] = '{op:2'b00, px:0,   py:0,   col:3'b000, shape:6'b000000, bits:49'd0,
                stall_at:0,   exp_plots:19200, exp_cycles:19201};
    vecs[1] = '{op:2'b01, px:0,   py:0,   col:3'b000, shape:6'b000000, bits:49'd0,
                stall_at:0,   exp_plots:2400,  exp_cycles:2401};
    vecs[2] = '{op:2'b10, px:158, py:10,  col:3'b111, shape:6'b000000, bits:{49{1'b1}},
                stall_at:0,   exp_plots:14,    exp_cycles:50};
    vecs[3] = '{op:2'b11, px:156, py:0,   col:3'b110, shape:6'b110010, bits:49'd0,
                stall_at:0,   exp_plots:240,   exp_cycles:241};
    vecs[4] = '{op:2'b11, px:156, py:0,   col:3'b110, shape:6'b110010, bits:49'd0,
                stall_at:100, exp_plots:240,   exp_cycles:244};
    vecs[5] = '{op:2'b10, px:5,   py:5,   col:3'b101, shape:6'b000000, bits:49'h0AAAAAAAAAAAA,
                stall_at:0,   exp_plots:24,    exp_cycles:50};
    vecs[6] = '{op:2'b10, px:150, py:116, col:3'b011, shape:6'b000000, bits:{49{1'b1}},
                stall_at:0,   exp_plots:28,    exp_cycles:50};
    vecs[7] = '{op:2'b11, px:159, py:0,   col:3'b001, shape:6'b000000, bits:49'd0,
                stall_at:0,   exp_plots:120,   exp_cycles:241};

    // Reset state, checked while reset is held with the clock running.
    repeat (3) @(negedge clk);
    check_output("rst_ready", cmd_ready, 1);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_plot", plot, 0);
    check_output("rst_x", x, 0);
    check_output("rst_y", y, 0);
    check_output("rst_color", color, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) apply_stimulus(i, 1'b0);

    // CLEAR aborted by reset once 500 pixels have been taken.
    @(negedge clk);
    cmd_op     = 2'b00;
    cmd_valid  = 1'b1;
    plot_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    plots     = 0;
    cyc       = 0;
    while (plots < 500 && cyc < 2000) begin
      if (plot && plot_ready) plots++;
      @(negedge clk);
      cyc++;
    end
    check_output("abort_point", plots, 500);
    check_output("busy_before_abort", busy, 1);
    reset_n = 1'b0;
    #1;
    check_output("abort_plot", plot, 0);
    check_output("abort_busy", busy, 0);
    check_output("abort_done", done, 0);
    check_output("abort_ready", cmd_ready, 1);
    repeat (3) begin
      @(negedge clk);
      check_output("abort_no_done", done, 0);
    end
    // Offer FLOORS before release so it is taken on the first edge after.
    cmd_op    = 2'b01;
    cmd_valid = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    apply_stimulus(1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scene_raster_engine.md
SCENE_RASTER_ENGINE -- requirements
Module: scene_raster_engine

Interface
REQ-001 SHALL provide parameters (name, default, meaning):
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- COLOR_W, 3, colour width
- NUM_LANES, 3, number of floor lanes
- LANE_PITCH, 40, rows per lane
- FLOOR_H, 5, floor band rows at the bottom of each lane
- TOP_GAP_H, 15, top-gap rows
- BOT_GAP_H, 5, bottom-gap rows above the floor
- COL_W, 2, obstacle column width
- SPR_W, 7, sprite width
- SPR_H, 7, sprite height
- FLOOR_COLOR, 3'b010
- BG_COLOR, 3'b000

REQ-002 SHALL provide ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge
- reset_n, in, 1, asynchronous active-low reset
- cmd_valid, in, 1, command offered
- cmd_ready, out, 1, engine idle and able to accept a command
- cmd_op, in, 2, command code: 00 CLEAR, 01 FLOORS, 10 SPRITE, 11 COLUMN
- cmd_x, in, X_W, region origin x
- cmd_y, in, Y_W, region origin y
- cmd_color, in, COLOR_W, sprite or wall colour
- cmd_shape, in, 2*NUM_LANES, per-lane shape code; bits [2i+1:2i] are lane i, lane 0 is the top lane
- sprite_bits, in, SPR_W*SPR_H, sprite bitmap; bit r*SPR_W+c is row r, column c
- plot, out, 1, pixel write strobe
- plot_ready, in, 1, downstream accepts the pixel
- x, out, X_W, pixel x
- y, out, Y_W, pixel y
- color, out, COLOR_W, pixel colour
- busy, out, 1, a command is executing
- done, out, 1, one-cycle completion pulse

Function
REQ-003 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; cmd_ready=1 only in IDLE; busy=1 only in RUN.
REQ-004 SHALL accept a command on a rising edge with cmd_valid & cmd_ready and latch every cmd_* field and sprite_bits; input changes while in RUN have no effect.
REQ-005 SHALL scan the command region in raster order, x fastest; the first candidate pixel appears in the cycle after accept.
REQ-006 SHALL advance the scan only when plot=0, or when plot=1 and plot_ready=1; while stalled, x, y and color SHALL hold stable.
REQ-007 SHALL enter DONE in the cycle after the last pixel is consumed, assert done for exactly one cycle, and then return to IDLE.
REQ-008 SHALL compute coordinates with one guard bit; a pixel with x>=SCREEN_W or y>=SCREEN_H SHALL be clipped (plot=0, still costs one cycle), and no coordinate SHALL wrap.
REQ-009 SHALL define lane i's floor band as rows (i+1)*LANE_PITCH-FLOOR_H through (i+1)*LANE_PITCH-1.
REQ-010 SHALL execute CLEAR over the full screen with plot on every pixel: FLOOR_COLOR in floor bands, BG_COLOR elsewhere.
REQ-011 SHALL execute FLOORS over the full width on floor-band rows only: plot on every pixel, FLOOR_COLOR, and a direct jump from each band's last row to the next band's first row with no idle cycles.
REQ-012 SHALL execute SPRITE over SPR_W x SPR_H pixels from (cmd_x, cmd_y): plot only where the bitmap bit is 1 and the pixel is unclipped, color=cmd_color; a 0 bit costs one cycle with plot=0.
REQ-013 SHALL execute COLUMN over COL_W columns from cmd_x, rows 0 to SCREEN_H-1, plotting every unclipped pixel:
- lane i top-gap rows (first TOP_GAP_H rows of the lane): BG_COLOR if the lane shape is 00 or 01, else cmd_color
- lane i bottom-gap rows (BOT_GAP_H rows directly above the floor): BG_COLOR if the shape is 10, else cmd_color
- other non-floor rows: cmd_color
- floor-band rows: FLOOR_COLOR
REQ-014 SHALL drive plot=0 in IDLE and DONE, and keep the registered x, y and color unchanged.

Reset
REQ-015 SHALL, while reset_n=0 and regardless of clk, hold: state IDLE, cmd_ready=1, busy=0, done=0, plot=0, x=0, y=0, color=0, scan counters 0.
REQ-016 SHALL, when reset asserts mid-command, abort the command immediately with no done pulse, and accept a new command on the first edge after release.

Verification
REQ-017 CLEAR with plot_ready=1 -> 19200 plots; (0,34) colour 000, (0,35) colour 010, (159,119) colour 010; done 19201 cycles after accept.
REQ-018 FLOORS -> exactly 2400 plots, y sequence 35..39, 75..79, 115..119, every colour 010, no gap cycles.
REQ-019 SPRITE at (158,10), all-ones bitmap, cmd_color=111 -> 14 plots at x in {158,159}, y 10..16; 49 scan cycles, then done.
REQ-020 COLUMN cmd_x=156, cmd_shape=6'b11_00_10, cmd_color=110 -> rows 0-29 colour 110, rows 30-34 000, 40-54 000, 80-114 110, floor rows 010; 240 plots.
REQ-021 Same COLUMN with plot_ready low for 3 cycles mid-scan -> x, y and color held; 240 plots total; done 3 cycles later than the unstalled run.
REQ-022 reset_n pulsed low during CLEAR at pixel 500 -> plot=0 and busy=0 at once, no done; a subsequent FLOORS completes normally.
